// File: rtl/p_cacheline_adaptor.sv
// Turns one 256-bit cache-line read/write into a 4-beat 64-bit burst; pmem_resp pulses one cycle after the last beat (min 5 cycles).
// Backpressure: the burst stalls on any cycle without bmem_resp; a new request is taken only from IDLE.
module p_cacheline_adaptor #(
    parameter int s_line    = 256,
    parameter int s_burst   = 64,
    parameter int s_offset  = 5,
    parameter int num_beats = s_line / s_burst
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pmem_read,
    input  logic                pmem_write,
    input  logic [31:0]         pmem_address,
    input  logic [s_line-1:0]   pmem_wdata,
    output logic [s_line-1:0]   pmem_rdata,
    output logic                pmem_resp,
    output logic                bmem_read,
    output logic                bmem_write,
    output logic [31:0]         bmem_address,
    output logic [s_burst-1:0]  bmem_wdata,
    input  logic [s_burst-1:0]  bmem_rdata,
    input  logic                bmem_resp
);

    localparam int s_cnt = $clog2(num_beats);
    localparam logic [31:0] addr_mask = ~((32'd1 << s_offset) - 32'd1);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } state_t;

    state_t              state;
    logic [s_cnt-1:0]    cnt;
    logic [s_cnt-1:0]    cnt_nxt;
    logic                last_beat;
    logic [31:0]         addr;
    logic [s_line-1:0]   rline;
    logic [s_line-1:0]   wline;

    assign cnt_nxt   = cnt + s_cnt'(1);
    assign last_beat = (cnt == s_cnt'(num_beats - 1));

    assign bmem_address = addr;
    assign pmem_rdata   = rline;

    // Read and write lines are kept apart so a write burst never disturbs
    // the last read line still visible on pmem_rdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            addr       <= '0;
            rline      <= '0;
            wline      <= '0;
            pmem_resp  <= 1'b0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pmem_resp <= 1'b0;
                    if (pmem_read) begin
                        state     <= RD_BURST;
                        addr      <= pmem_address & addr_mask;
                        cnt       <= '0;
                        bmem_read <= 1'b1;
                    end else if (pmem_write) begin
                        state      <= WR_BURST;
                        addr       <= pmem_address & addr_mask;
                        wline      <= pmem_wdata;
                        cnt        <= '0;
                        bmem_write <= 1'b1;
                        bmem_wdata <= pmem_wdata[s_burst-1:0];
                    end
                end
                RD_BURST: begin
                    if (bmem_resp) begin
                        rline[s_burst*cnt +: s_burst] <= bmem_rdata;
                        cnt <= cnt_nxt;
                        if (last_beat) begin
                            state     <= DONE;
                            bmem_read <= 1'b0;
                            pmem_resp <= 1'b1;
                        end
                    end
                end
                WR_BURST: begin
                    if (bmem_resp) begin
                        cnt <= cnt_nxt;
                        if (last_beat) begin
                            state      <= DONE;
                            bmem_write <= 1'b0;
                            bmem_wdata <= '0;
                            pmem_resp  <= 1'b1;
                        end else begin
                            // Present the following beat as soon as this one is accepted.
                            bmem_wdata <= wline[s_burst*cnt_nxt +: s_burst];
                        end
                    end
                end
                DONE: begin
                    pmem_resp <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_p_cacheline_adaptor.sv
// Directed plus randomized bench for p_cacheline_adaptor against a line/beat level memory model.
module tb_p_cacheline_adaptor;

    logic         clk;
    logic         rst;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         bmem_read;
    logic         bmem_write;
    logic [31:0]  bmem_address;
    logic [63:0]  bmem_wdata;
    logic [63:0]  bmem_rdata;
    logic         bmem_resp;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    p_cacheline_adaptor dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .bmem_read    (bmem_read),
        .bmem_write   (bmem_write),
        .bmem_address (bmem_address),
        .bmem_wdata   (bmem_wdata),
        .bmem_rdata   (bmem_rdata),
        .bmem_resp    (bmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    // Entered in the first burst cycle. Beat j of the line is line[64*j +: 64];
    // response pattern bits are used first, then random responses.
    task automatic read_burst(input logic [31:0] a, input logic [255:0] line,
                              input logic [31:0] pat, input int plen, output int done_cyc);
        int k = 0;
        int i = 0;
        logic r;
        pmem_address = $urandom;
        pmem_wdata   = rand_line();
        while (k < 4 && i < 64) begin
            chk("rd_bmem_read", bmem_read, 1);
            chk("rd_bmem_write", bmem_write, 0);
            chk("rd_address", bmem_address, a & 32'hFFFF_FFE0);
            chk("rd_resp_early", pmem_resp, 0);
            r = (i < plen) ? pat[i] : ($urandom_range(0, 2) != 0);
            bmem_resp  = r;
            bmem_rdata = r ? line[64*k +: 64] : {$urandom, $urandom};
            tick();
            if (r) k++;
            i++;
        end
        bmem_resp = 1'b0;
        chk("rd_beats_timeout", k, 4);
        chk("rd_done_resp", pmem_resp, 1);
        chk("rd_done_bmem_read", bmem_read, 0);
        chk("rd_line", pmem_rdata, line);
        done_cyc  = cyc;
        pmem_read = 1'b0;
        tick();
        chk("rd_idle_resp", pmem_resp, 0);
        chk("rd_idle_bmem_read", bmem_read, 0);
    endtask

    task automatic write_burst(input logic [31:0] a, input logic [255:0] wd);
        int k = 0;
        int i = 0;
        logic r;
        pmem_address = $urandom;
        pmem_wdata   = rand_line();
        while (k < 4 && i < 64) begin
            chk("wr_bmem_write", bmem_write, 1);
            chk("wr_bmem_read", bmem_read, 0);
            chk("wr_address", bmem_address, a & 32'hFFFF_FFE0);
            chk("wr_beat", bmem_wdata, wd[64*k +: 64]);
            chk("wr_resp_early", pmem_resp, 0);
            r = ($urandom_range(0, 2) != 0);
            bmem_resp = r;
            tick();
            if (r) k++;
            i++;
        end
        bmem_resp = 1'b0;
        chk("wr_beats_timeout", k, 4);
        chk("wr_done_resp", pmem_resp, 1);
        chk("wr_done_bmem_write", bmem_write, 0);
        pmem_write = 1'b0;
        tick();
        chk("wr_idle_resp", pmem_resp, 0);
        chk("wr_idle_bmem_write", bmem_write, 0);
    endtask

    initial begin
        logic [255:0] line;
        logic [255:0] last_rd;
        logic [31:0]  a;
        int           dc;

        rst          = 1'b0;
        pmem_read    = 1'b1;
        pmem_write   = 1'b0;
        pmem_address = 32'h0000_1234;
        pmem_wdata   = '0;
        bmem_rdata   = '0;
        bmem_resp    = 1'b0;

        // Reset held with a pending read: everything stays quiet.
        tick();
        tick();
        chk("rst_pmem_resp", pmem_resp, 0);
        chk("rst_bmem_read", bmem_read, 0);
        chk("rst_bmem_write", bmem_write, 0);
        chk("rst_bmem_address", bmem_address, 0);
        chk("rst_bmem_wdata", bmem_wdata, 0);
        chk("rst_pmem_rdata", pmem_rdata, 0);
        rst = 1'b1;
        tick();
        line = rand_line();
        read_burst(32'h0000_1234, line, 32'h0, 0, dc);

        // Back-to-back beats with fixed data and minimum latency.
        line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        pmem_read = 1'b1;
        pmem_address = 32'h0000_1234;
        cyc = 0;
        tick();
        read_burst(32'h0000_1234, line, 32'hFFFF_FFFF, 32, dc);
        chk("b2b_latency", dc, 5);
        last_rd = line;

        // Gapped read: responses 1,0,0,1,1,0,1.
        line = rand_line();
        pmem_read = 1'b1;
        pmem_address = 32'h0000_2000;
        tick();
        read_burst(32'h0000_2000, line, 32'h59, 7, dc);
        last_rd = line;

        // Directed write A,B,C,D; the read line must survive it.
        pmem_write = 1'b1;
        pmem_address = 32'h8000_0040;
        pmem_wdata = {64'hD, 64'hC, 64'hB, 64'hA};
        tick();
        write_burst(32'h8000_0040, {64'hD, 64'hC, 64'hB, 64'hA});
        chk("rdata_hold_after_write", pmem_rdata, last_rd);

        // Randomized mix of reads and writes.
        for (int n = 0; n < 8; n++) begin
            a = $urandom;
            line = rand_line();
            pmem_address = a;
            if ($urandom_range(0, 1) == 1) begin
                pmem_read = 1'b1;
                tick();
                read_burst(a, line, 32'h0, 0, dc);
                last_rd = line;
            end else begin
                pmem_write = 1'b1;
                pmem_wdata = line;
                tick();
                write_burst(a, line);
                chk("rand_rdata_hold", pmem_rdata, last_rd);
            end
        end

        // Read and write together: read first, then the re-presented write.
        a = 32'h0000_3010;
        line = rand_line();
        pmem_read = 1'b1;
        pmem_write = 1'b1;
        pmem_address = a;
        tick();
        chk("both_write_held_off", bmem_write, 0);
        read_burst(a, line, 32'h0, 0, dc);
        pmem_address = 32'h0000_4020;
        line = rand_line();
        pmem_wdata = line;
        tick();
        write_burst(32'h0000_4020, line);

        // Reset after two read beats, then a fresh full read.
        a = 32'h0000_5000;
        line = rand_line();
        pmem_read = 1'b1;
        pmem_address = a;
        tick();
        for (int j = 0; j < 2; j++) begin
            bmem_resp = 1'b1;
            bmem_rdata = line[64*j +: 64];
            tick();
        end
        bmem_resp = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_bmem_read", bmem_read, 0);
        chk("midrst_pmem_resp", pmem_resp, 0);
        chk("midrst_bmem_address", bmem_address, 0);
        chk("midrst_pmem_rdata", pmem_rdata, 0);
        tick();
        chk("midrst_no_resp", pmem_resp, 0);
        rst = 1'b1;
        tick();
        line = rand_line();
        read_burst(a, line, 32'h0, 0, dc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/p_cacheline_adaptor.md
# p_cacheline_adaptor

Memory-side responder for the cache `pmem_*` interface. It accepts one 256-bit cache-line read or write request from a cache, such as the pipelined instruction cache or the data cache. It then converts the request into a four-beat, 64-bit burst transaction on the physical-memory bus. `pmem_resp` is returned as a single-cycle pulse once the whole line has been transferred.

## Interface
Parameters:
- `s_line`, 256: cache line width in bits.
- `s_burst`, 64: burst beat width in bits.
- `s_offset`, 5: line-offset bits cleared on the burst address.
- `num_beats`, `s_line/s_burst` (4): beats per line.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; `rst`=0 forces the reset state immediately.
- `pmem_read`  in  1  cache line-read request; held until `pmem_resp`.
- `pmem_write`  in  1  cache line-write request; held until `pmem_resp`.
- `pmem_address`  in  32  line address from the cache.
- `pmem_wdata`  in  256  line to write.
- `pmem_rdata`  out  256  assembled read line.
- `pmem_resp`  out  1  one-cycle completion pulse.
- `bmem_read`  out  1  burst read request.
- `bmem_write`  out  1  burst write request.
- `bmem_address`  out  32  burst address, line aligned.
- `bmem_wdata`  out  64  current write beat.
- `bmem_rdata`  in  64  current read beat.
- `bmem_resp`  in  1  beat valid or accepted in this cycle.

## Operation
- **States:** IDLE, RD_BURST, WR_BURST, DONE. The beat counter `cnt` is 2 bits wide, sized `$clog2(num_beats)`.
- **IDLE:**
  - If `pmem_read`=1: latch `pmem_address & ~32'h1F`, clear `cnt`, go to RD_BURST.
  - Else if `pmem_write`=1: latch the address and `pmem_wdata`, clear `cnt`, go to WR_BURST.
  - If both requests are high, read wins; the write is not lost, because the cache still holds it after the read completes.
  - `bmem_resp` is ignored in IDLE.
- **RD_BURST:**
  - Outputs: `bmem_read`=1, `bmem_address` = latched address.
  - On each cycle with `bmem_resp`=1: write `bmem_rdata` into line slot `[64*cnt +: 64]` and increment `cnt`.
  - On the beat where `cnt`=3, go to DONE.
  - Cycles with `bmem_resp`=0 stall with no change, so gaps between beats are legal.
- **WR_BURST:**
  - Outputs: `bmem_write`=1, `bmem_wdata` = latched line `[64*cnt +: 64]`.
  - `cnt` advances on each `bmem_resp` cycle.
  - On the beat where `cnt`=3, go to DONE.
- **DONE:**
  - `pmem_resp`=1 for exactly one cycle; `bmem_read` and `bmem_write` are 0.
  - The next state is always IDLE.
  - The cache deasserts its request in the cycle after it sees `pmem_resp`, so the IDLE state that follows does not re-accept the finished request.
- **Read data hold:** `pmem_rdata` is driven from the line register and holds its value until the next read overwrites slots. It is valid in the DONE cycle and afterwards until a new read begins.
- **Address and data latching:** the address and write data are captured at acceptance. Changes to the `pmem_*` inputs during a burst have no effect.

## Timing
- **Reset values:** state IDLE, `cnt`=0, line register 0, latched address 0. All outputs are 0: `pmem_resp`, `bmem_read`, `bmem_write`, `bmem_address`, `bmem_wdata`, `pmem_rdata`.
- **Acceptance and burst request:** a request seen in cycle 0 is accepted at the edge ending cycle 0. `bmem_read` or `bmem_write` is high from cycle 1.
- **Completion:**
  - With beats arriving on cycles b0..b3, `pmem_resp` is high in cycle b3+1.
  - Minimum latency, with `bmem_resp` high in cycles 1-4: `pmem_resp` in cycle 5.
- **Back-to-back requests:** IDLE is occupied for at least one cycle after DONE, so the next request is accepted no earlier than DONE+1.
- **Reset mid-burst:** `rst` low during RD_BURST or WR_BURST immediately returns to IDLE and clears all outputs; no `pmem_resp` is issued. After release, a held request restarts from beat 0.
- **Outputs are registered or decoded from state only:** no combinational path from `bmem_resp` to `pmem_resp`.

## Test plan
- **Reset values:** hold `rst`=0 with `pmem_read`=1 -> all outputs 0, no `bmem_read`. Release `rst` -> `bmem_read`=1 in the next cycle.
- **Back-to-back read:**
  - Stimulus: read at address `0x0000_1234`; memory returns beats `0x11..11`, `0x22..22`, `0x33..33`, `0x44..44` on consecutive cycles.
  - Response: `bmem_address`=`0x0000_1220`; `pmem_rdata`=`{0x44..44, 0x33..33, 0x22..22, 0x11..11}`; `pmem_resp` high exactly once, 5 cycles after request.
- **Read with gaps:** `bmem_resp` pattern 1,0,0,1,1,0,1 -> line assembled correctly; `pmem_resp` one cycle after the 4th beat.
- **Write:**
  - Stimulus: write `pmem_wdata`=`{64'hD, 64'hC, 64'hB, 64'hA}` at `0x8000_0040`.
  - Response: `bmem_wdata` = A, B, C, D across successive `bmem_resp` cycles; `bmem_write` drops in the DONE cycle.
- **Simultaneous read and write:** both held -> read burst first, `pmem_resp`, then a write burst after the cache re-presents the write.
- **Reset mid-burst:** assert `rst`=0 after 2 read beats -> outputs 0 immediately, no `pmem_resp`. Release with the request held -> a fresh 4-beat read.
